if_fetch_buf: RTL and testbench

IF_FETCH_BUF -- requirements
Module: if_fetch_buf

---
 rtl/if_fetch_buf_pkg.sv | 27 ++
 rtl/if_fetch_buf_if.sv | 26 ++
 rtl/if_fetch_buf_sync_fifo.sv | 51 +++++
 rtl/if_fetch_buf.sv | 114 +++++++++++
 tb/tb_if_fetch_buf.sv | 482 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_buf_pkg.sv
// Shared fetch-stage types and constants.
// Defines the IF->ID bundle layout, reset PC and request size.
package if_fetch_buf_pkg;

  localparam logic [31:0] PC_RESET_DEF = 32'h1C00_0000;
  localparam int IF_TO_ID_WIDTH = 65;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef struct packed {
    logic adef;
    logic [31:0] inst;
    logic [31:0] pc;
  } if_id_t;

  function automatic if_id_t mk_if_id(
    input logic adef,
    input logic [31:0] inst,
    input logic [31:0] pc
  );
    if_id_t b;
    b.adef = adef;
    b.inst = inst;
    b.pc = pc;
    return b;
  endfunction

endpackage

// File: rtl/if_fetch_buf_if.sv
// SRAM-like instruction request/response channel.
// master: fetch unit drives request; slave: memory side.
interface if_fetch_buf_if;

  logic inst_req;
  logic inst_wr;
  logic [1:0] inst_size;
  logic [31:0] inst_addr;
  logic [31:0] inst_wdata;
  logic inst_addr_ok;
  logic inst_data_ok;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req, inst_wr, inst_size,
    output inst_addr, inst_wdata,
    input inst_addr_ok, inst_data_ok, inst_rdata
  );

  modport slave (
    input inst_req, inst_wr, inst_size,
    input inst_addr, inst_wdata,
    output inst_addr_ok, inst_data_ok, inst_rdata
  );

endinterface

// File: rtl/if_fetch_buf_sync_fifo.sv
// Synchronous FIFO with flush; push and pop may coincide at full.
// Ports: clk, resetn, flush, push/din, pop/dout (head), count.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic flush,
  input  logic push,
  input  logic [WIDTH-1:0] din,
  input  logic pop,
  output logic [WIDTH-1:0] dout,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_N = DEPTH[CW-1:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic empty;
  logic full;
  logic do_push;
  logic do_pop;

  assign empty = (count == '0);
  assign full = (count == FULL_N);
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop) rp <= rp + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/if_fetch_buf.sv
// Instruction fetch stage with in-flight PC queue and instruction buffer.
// Ports: clk, resetn, bus (SRAM master), ID handshake, branch/exception redirect.
module if_fetch_buf
  import if_fetch_buf_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEF,
  parameter int IBUF_DEPTH = 4
) (
  input  logic clk,
  input  logic resetn,
  if_fetch_buf_if.master bus,
  input  logic id_allowin,
  input  logic br_taken,
  input  logic [31:0] br_target,
  input  logic ex_flush,
  input  logic [31:0] ex_entry,
  output logic if_to_id_valid,
  output logic [IF_TO_ID_WIDTH-1:0] if_to_id_bus
);

  localparam int CW = $clog2(IBUF_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = IBUF_DEPTH[CW:0];

  logic [31:0] fetch_pc;
  logic [31:0] redir_pc;
  logic [31:0] pq_head;
  logic [CW-1:0] outst;
  logic [CW-1:0] discard;
  logic [CW-1:0] pq_cnt;
  logic [CW-1:0] ib_cnt;
  logic [CW:0] occ;
  logic adef_done;
  logic redirect;
  logic hs;
  logic ok_any;
  logic drop;
  logic take;
  logic adef_push;
  logic ib_pop;
  if_id_t ib_din;

  assign redirect = ex_flush | br_taken;
  assign redir_pc = ex_flush ? ex_entry : br_target;

  // outst counts every request still owed a response on the bus,
  // including ones already marked for discard.
  assign occ = {1'b0, outst} + {1'b0, ib_cnt};

  assign bus.inst_req = resetn & ~redirect
                      & (fetch_pc[1:0] == 2'b00)
                      & (occ < DEPTH_W);
  assign bus.inst_wr = 1'b0;
  assign bus.inst_size = SIZE_WORD;
  assign bus.inst_addr = fetch_pc;
  assign bus.inst_wdata = 32'h0;

  assign hs = bus.inst_req & bus.inst_addr_ok;
  assign ok_any = bus.inst_data_ok & (outst != '0);
  assign drop = ok_any & (redirect | (discard != '0));
  assign take = ok_any & ~drop & (pq_cnt != '0);

  assign adef_push = ~redirect & ~adef_done
                   & (fetch_pc[1:0] != 2'b00)
                   & (outst == '0)
                   & (occ < DEPTH_W);

  assign ib_din = adef_push
                ? mk_if_id(1'b1, 32'h0, fetch_pc)
                : mk_if_id(1'b0, bus.inst_rdata, pq_head);

  assign if_to_id_valid = resetn & (ib_cnt != '0);
  assign ib_pop = if_to_id_valid & id_allowin & ~redirect;

  sync_fifo #(.WIDTH(32), .DEPTH(IBUF_DEPTH)) u_pcq (
    .clk(clk),
    .resetn(resetn),
    .flush(redirect),
    .push(hs),
    .din(fetch_pc),
    .pop(take),
    .dout(pq_head),
    .count(pq_cnt)
  );

  sync_fifo #(.WIDTH(IF_TO_ID_WIDTH), .DEPTH(IBUF_DEPTH)) u_ibuf (
    .clk(clk),
    .resetn(resetn),
    .flush(redirect),
    .push(take | adef_push),
    .din(ib_din),
    .pop(ib_pop),
    .dout(if_to_id_bus),
    .count(ib_cnt)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      fetch_pc <= PC_RESET;
      outst <= '0;
      discard <= '0;
      adef_done <= 1'b0;
    end else begin
      if (redirect) fetch_pc <= redir_pc;
      else if (hs) fetch_pc <= fetch_pc + 32'd4;
      outst <= outst + CW'(hs) - CW'(ok_any);
      // all requests still owed after this cycle become stale
      if (redirect) discard <= outst - CW'(ok_any);
      else if (drop) discard <= discard - CW'(1);
      if (redirect) adef_done <= 1'b0;
      else if (adef_push) adef_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_fetch_buf.sv
// Self-checking bench for if_fetch_buf.
// Memory model answers in order; expected stream derived from PC rules.
module tb_if_fetch_buf;
  import if_fetch_buf_pkg::*;

  localparam logic [31:0] PC0 = 32'h1C00_0000;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic id_allowin = 1'b0;
  logic br_taken = 1'b0;
  logic ex_flush = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic [31:0] ex_entry = 32'h0;
  logic if_to_id_valid;
  logic [64:0] if_to_id_bus;

  if_fetch_buf_if bus();

  if_fetch_buf #(.PC_RESET(PC0), .IBUF_DEPTH(DEPTH)) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus),
    .id_allowin(id_allowin),
    .br_taken(br_taken),
    .br_target(br_target),
    .ex_flush(ex_flush),
    .ex_entry(ex_entry),
    .if_to_id_valid(if_to_id_valid),
    .if_to_id_bus(if_to_id_bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] addr_q[$];
  int mode = 2;
  logic aok_hold = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0F0F_3C3C;
  endfunction

  function automatic logic [64:0] good(input logic [31:0] pc);
    return {1'b0, mem_word(pc), pc};
  endfunction

  // mode 0: zero-wait, 1: random, 2: addr_ok=aok_hold, no data
  task automatic mem_drive();
    case (mode)
      0: begin
        bus.inst_addr_ok = 1'b1;
        bus.inst_data_ok = 1'b1;
      end
      1: begin
        bus.inst_addr_ok = ($urandom % 4) != 0;
        bus.inst_data_ok = addr_q.size() > 0 && ($urandom % 3) != 0;
      end
      default: begin
        bus.inst_addr_ok = aok_hold;
        bus.inst_data_ok = 1'b0;
      end
    endcase
    bus.inst_rdata = addr_q.size() > 0 ? mem_word(addr_q[0]) : 32'hDEAD_BEEF;
    #1;
  endtask

  task automatic tick();
    logic hs;
    logic dok;
    logic [31:0] a;
    hs = bus.inst_req & bus.inst_addr_ok;
    dok = bus.inst_data_ok;
    a = bus.inst_addr;
    @(posedge clk);
    #1;
    if (!resetn) begin
      addr_q.delete();
    end else begin
      if (dok && addr_q.size() > 0) void'(addr_q.pop_front());
      if (hs) addr_q.push_back(a);
    end
  endtask

  task automatic idle_inputs();
    id_allowin = 1'b0;
    br_taken = 1'b0;
    ex_flush = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    idle_inputs();
    mode = 2;
    aok_hold = 1'b0;
    mem_drive();
    repeat (2) @(posedge clk);
    #1;
    addr_q.delete();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle_inputs();
    mode = 2;
    aok_hold = 1'b0;
    mem_drive();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.inst_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_req got %b want 0", bus.inst_req);
    end
    checks++;
    if (if_to_id_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid got %b want 0", if_to_id_valid);
    end
    checks++;
    if (bus.inst_addr !== PC0) begin
      errors++;
      $display("FAIL rst_pc got %h want %h", bus.inst_addr, PC0);
    end
    checks++;
    if ({bus.inst_wr, bus.inst_size, bus.inst_wdata} !== {1'b0, 2'b10, 32'h0}) begin
      errors++;
      $display("FAIL rst_const got %b %b %h want 0 10 0",
               bus.inst_wr, bus.inst_size, bus.inst_wdata);
    end
    addr_q.delete();
    resetn = 1'b1;
    mem_drive();
    checks++;
    if (bus.inst_req !== 1'b1 || bus.inst_addr !== PC0) begin
      errors++;
      $display("FAIL first_req got %b %h want 1 %h", bus.inst_req, bus.inst_addr, PC0);
    end
  endtask

  task automatic test_zero_wait();
    logic [64:0] exp;
    do_reset();
    mode = 0;
    id_allowin = 1'b1;
    for (int k = 0; k < 16; k++) begin
      mem_drive();
      checks++;
      if (bus.inst_req !== 1'b1) begin
        errors++;
        $display("FAIL zw_req k=%0d got %b want 1", k, bus.inst_req);
      end
      checks++;
      if (k >= 2) begin
        exp = good(PC0 + 32'(4 * (k - 2)));
        if (if_to_id_valid !== 1'b1 || if_to_id_bus !== exp) begin
          errors++;
          $display("FAIL zw_out k=%0d got %b %h want 1 %h", k, if_to_id_valid, if_to_id_bus, exp);
        end
      end else if (if_to_id_valid !== 1'b0) begin
        errors++;
        $display("FAIL zw_lat k=%0d got %b want 0", k, if_to_id_valid);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int n_hs;
    int got;
    logic last_req;
    logic [31:0] exp_pc;
    do_reset();
    mode = 0;
    id_allowin = 1'b0;
    n_hs = 0;
    last_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      mem_drive();
      if (bus.inst_req && bus.inst_addr_ok) n_hs++;
      last_req = bus.inst_req;
      tick();
    end
    checks++;
    if (n_hs != DEPTH) begin
      errors++;
      $display("FAIL bp_hs got %0d want %0d", n_hs, DEPTH);
    end
    checks++;
    if (last_req !== 1'b0) begin
      errors++;
      $display("FAIL bp_stall got %b want 0", last_req);
    end
    id_allowin = 1'b1;
    exp_pc = PC0;
    got = 0;
    for (int k = 0; k < 30 && got < 8; k++) begin
      mem_drive();
      if (if_to_id_valid) begin
        checks++;
        if (if_to_id_bus !== good(exp_pc)) begin
          errors++;
          $display("FAIL bp_out got %h want %h", if_to_id_bus, good(exp_pc));
        end
        exp_pc += 32'd4;
        got++;
      end
      tick();
    end
    checks++;
    if (got < 8) begin
      errors++;
      $display("FAIL bp_timeout got %0d want 8", got);
    end
  endtask

  task automatic test_branch_discard();
    int n_dok;
    logic found;
    do_reset();
    mode = 2;
    aok_hold = 1'b1;
    id_allowin = 1'b0;
    repeat (3) begin
      mem_drive();
      tick();
    end
    br_taken = 1'b1;
    br_target = 32'h1C00_0100;
    mem_drive();
    checks++;
    if (bus.inst_req !== 1'b0) begin
      errors++;
      $display("FAIL br_req got %b want 0", bus.inst_req);
    end
    tick();
    br_taken = 1'b0;
    mem_drive();
    checks++;
    if (bus.inst_addr !== 32'h1C00_0100) begin
      errors++;
      $display("FAIL br_pc got %h want 1c000100", bus.inst_addr);
    end
    mode = 1;
    id_allowin = 1'b1;
    n_dok = 0;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      mem_drive();
      if (if_to_id_valid) begin
        found = 1'b1;
        checks++;
        if (n_dok != 4) begin
          errors++;
          $display("FAIL br_drop got %0d responses want 4", n_dok);
        end
        checks++;
        if (if_to_id_bus !== good(32'h1C00_0100)) begin
          errors++;
          $display("FAIL br_first got %h want %h", if_to_id_bus, good(32'h1C00_0100));
        end
      end
      if (bus.inst_data_ok) n_dok++;
      tick();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL br_timeout got no output want one");
    end
  endtask

  task automatic test_flush_priority();
    logic found;
    do_reset();
    mode = 1;
    id_allowin = 1'b1;
    repeat (5) begin
      mem_drive();
      tick();
    end
    ex_flush = 1'b1;
    ex_entry = 32'h1C00_1000;
    br_taken = 1'b1;
    br_target = 32'h1C00_0200;
    mem_drive();
    tick();
    ex_flush = 1'b0;
    br_taken = 1'b0;
    mem_drive();
    checks++;
    if (bus.inst_addr !== 32'h1C00_1000) begin
      errors++;
      $display("FAIL ex_pc got %h want 1c001000", bus.inst_addr);
    end
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (k > 0) mem_drive();
      if (if_to_id_valid) begin
        found = 1'b1;
        checks++;
        if (if_to_id_bus !== good(32'h1C00_1000)) begin
          errors++;
          $display("FAIL ex_first got %h want %h", if_to_id_bus, good(32'h1C00_1000));
        end
      end
      tick();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL ex_timeout got no output want one");
    end
  endtask

  task automatic test_adef();
    logic found;
    logic [64:0] exp;
    exp = {1'b1, 32'h0, 32'h1C00_0102};
    do_reset();
    mode = 1;
    id_allowin = 1'b1;
    repeat (4) begin
      mem_drive();
      tick();
    end
    id_allowin = 1'b0;
    br_taken = 1'b1;
    br_target = 32'h1C00_0102;
    mem_drive();
    tick();
    br_taken = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      mem_drive();
      checks++;
      if (bus.inst_req !== 1'b0) begin
        errors++;
        $display("FAIL adef_req got %b want 0", bus.inst_req);
      end
      if (if_to_id_valid) found = 1'b1;
      else tick();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL adef_timeout got no output want one");
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (if_to_id_valid !== 1'b1 || if_to_id_bus !== exp) begin
        errors++;
        $display("FAIL adef_hold got %b %h want 1 %h", if_to_id_valid, if_to_id_bus, exp);
      end
      tick();
      mem_drive();
    end
    id_allowin = 1'b1;
    tick();
    for (int k = 0; k < 6; k++) begin
      mem_drive();
      checks++;
      if (if_to_id_valid !== 1'b0 || bus.inst_req !== 1'b0) begin
        errors++;
        $display("FAIL adef_once got %b %b want 0 0", if_to_id_valid, bus.inst_req);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    int got;
    logic [31:0] exp_pc;
    do_reset();
    mode = 0;
    id_allowin = 1'b0;
    repeat (2) begin
      mem_drive();
      tick();
    end
    mode = 2;
    aok_hold = 1'b1;
    mem_drive();
    tick();
    aok_hold = 1'b0;
    mem_drive();
    checks++;
    if (if_to_id_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre got %b want 1", if_to_id_valid);
    end
    resetn = 1'b0;
    tick();
    mem_drive();
    checks++;
    if (bus.inst_req !== 1'b0 || if_to_id_valid !== 1'b0 || bus.inst_addr !== PC0) begin
      errors++;
      $display("FAIL mid_rst got %b %b %h want 0 0 %h",
               bus.inst_req, if_to_id_valid, bus.inst_addr, PC0);
    end
    resetn = 1'b1;
    mode = 1;
    id_allowin = 1'b1;
    exp_pc = PC0;
    got = 0;
    for (int k = 0; k < 200 && got < 3; k++) begin
      mem_drive();
      if (if_to_id_valid) begin
        checks++;
        if (if_to_id_bus !== good(exp_pc)) begin
          errors++;
          $display("FAIL mid_out got %h want %h", if_to_id_bus, good(exp_pc));
        end
        exp_pc += 32'd4;
        got++;
      end
      tick();
    end
    checks++;
    if (got < 3) begin
      errors++;
      $display("FAIL mid_timeout got %0d want 3", got);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    int r;
    int got;
    do_reset();
    mode = 1;
    exp_pc = PC0;
    got = 0;
    for (int k = 0; k < 3000; k++) begin
      id_allowin = ($urandom % 4) != 0;
      r = $urandom_range(0, 39);
      br_taken = (r == 0) || (r == 2);
      ex_flush = (r == 1) || (r == 2);
      br_target = PC0 + 32'(($urandom % 1024) * 4);
      ex_entry = PC0 + 32'h1_0000 + 32'(($urandom % 1024) * 4);
      mem_drive();
      if (if_to_id_valid && id_allowin && !br_taken && !ex_flush) begin
        checks++;
        if (if_to_id_bus !== good(exp_pc)) begin
          errors++;
          $display("FAIL rnd_out got %h want %h", if_to_id_bus, good(exp_pc));
        end
        exp_pc += 32'd4;
        got++;
      end
      if (ex_flush) exp_pc = ex_entry;
      else if (br_taken) exp_pc = br_target;
      tick();
    end
    idle_inputs();
    checks++;
    if (got < 200) begin
      errors++;
      $display("FAIL rnd_volume got %0d want >=200", got);
    end
  endtask

  initial begin
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b0;
    bus.inst_rdata = 32'h0;
    test_reset();
    test_zero_wait();
    test_backpressure();
    test_branch_discard();
    test_flush_priority();
    test_adef();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
